// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle carrying one DW-bit word per transfer.
// Master drives vld/dat and samples rdy; slave does the reverse.
// A word moves on a rising edge where vld and rdy are both high.
interface stream_fifo_if #(
  parameter int DW = 32
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] dat;

  modport master (output vld, output dat, input rdy);
  modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/stream_fifo.sv
// DEPTH-entry valid/ready FIFO with synchronous flush, fill level and almost-full flag.
// Latency: a word pushed on edge N is visible at the head after edge N (1 cycle min).
// Backpressure: push.rdy drops at full or during clr; no bypass path from pop.rdy.
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                clr,
  stream_fifo_if.slave        push,
  stream_fifo_if.master       pop,
  output logic [LW-1:0]       lvl,
  output logic                afull
);

  // Pointers need at least one bit even when DEPTH is 1.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [LW-1:0] cnt;
  logic          in_trn;
  logic          out_trn;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and status outputs straight from the held state; clr masks both sides.
  always_comb begin
    push.rdy = (cnt != LW'(DEPTH)) && !clr;
    pop.vld  = (cnt != '0) && !clr;
    pop.dat  = mem[rp];
    lvl      = cnt;
    afull    = (cnt >= LW'(AFULL));
    in_trn   = clk_en && push.vld && push.rdy;
    out_trn  = clk_en && pop.vld && pop.rdy;
  end

  // Storage write; contents are not reset, only the pointers and count are.
  always_ff @(posedge clk) begin
    if (in_trn) mem[wp] <= push.dat;
  end

  // Pointer and occupancy bookkeeping with flush and clock-enable hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clk_en) begin
      if (clr) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (in_trn)  wp <= ptr_next(wp);
        if (out_trn) rp <= ptr_next(rp);
        case ({in_trn, out_trn})
          2'b10:   cnt <= cnt + LW'(1);
          2'b01:   cnt <= cnt - LW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DW=8, DEPTH=3, AFULL=2).
// A queue model tracks contents from the handshake rules; outputs are
// compared mid-cycle before every rising edge.
module tb_stream_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int AFULL = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          clr;
  logic [LW-1:0] lvl;
  logic          afull;

  stream_fifo_if #(.DW(DW)) push_if ();
  stream_fifo_if #(.DW(DW)) pop_if ();

  stream_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .clr    (clr),
    .push   (push_if),
    .pop    (pop_if),
    .lvl    (lvl),
    .afull  (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] q [$];

  // Count one comparison and report it when it does not match.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model state, then apply one clock edge.
  task automatic step(input logic en, input logic fl, input logic iv,
                      input logic [DW-1:0] d, input logic ordy);
    logic exp_ir;
    logic exp_ov;
    clk_en      = en;
    clr         = fl;
    push_if.vld = iv;
    push_if.dat = d;
    pop_if.rdy  = ordy;
    #1;
    exp_ir = (q.size() != DEPTH) && !fl;
    exp_ov = (q.size() != 0) && !fl;
    chk("in_rdy", 32'(push_if.rdy), 32'(exp_ir));
    chk("out_vld", 32'(pop_if.vld), 32'(exp_ov));
    chk("lvl", 32'(lvl), 32'(q.size()));
    chk("afull", 32'(afull), 32'(q.size() >= AFULL));
    if (exp_ov) chk("out_dat", 32'(pop_if.dat), 32'(q[0]));
    @(posedge clk);
    if (en) begin
      if (fl) begin
        q.delete();
      end else begin
        if (ordy && exp_ov) void'(q.pop_front());
        if (iv && exp_ir) q.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    clk_en      = 1'b1;
    clr         = 1'b0;
    push_if.vld = 1'b0;
    push_if.dat = '0;
    pop_if.rdy  = 1'b0;
    #2;
    chk("rst_in_rdy", 32'(push_if.rdy), 32'd1);
    chk("rst_out_vld", 32'(pop_if.vld), 32'd0);
    chk("rst_lvl", 32'(lvl), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full with the consumer stalled, one extra offer must be refused.
    step(1, 0, 1, 8'h11, 0);
    step(1, 0, 1, 8'h22, 0);
    step(1, 0, 1, 8'h33, 0);
    step(1, 0, 1, 8'h44, 0);
    // Drain.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 8'h00, 1);

    // Continuous streaming, 20 words, pointers wrap several times.
    for (int i = 0; i < 20; i++) step(1, 0, 1, 8'(i), 1);
    // Consumer stall mid-stream for 3 cycles.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(20 + i), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(23 + i), 1);

    // Clock enable low for 5 cycles with both sides willing.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'hEE, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'(40 + i), 1);

    // Flush at full while a word is offered.
    while (q.size() < DEPTH) step(1, 0, 1, 8'h5A, 0);
    step(1, 1, 1, 8'hC3, 1);
    step(1, 0, 1, 8'hA5, 0);
    step(1, 0, 0, 8'h00, 0);
    // Flush while clock enable is low is ignored.
    step(0, 1, 1, 8'h77, 1);
    step(1, 0, 0, 8'h00, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0);

    // Asynchronous reset between edges at level 2.
    while (q.size() != 0) step(1, 0, 0, 8'h00, 1);
    step(1, 0, 1, 8'h61, 0);
    step(1, 0, 1, 8'h62, 0);
    chk("pre_arst_lvl", 32'(lvl), 32'd2);
    push_if.vld = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 32'(pop_if.vld), 32'd0);
    chk("arst_lvl", 32'(lvl), 32'd0);
    chk("arst_in_rdy", 32'(push_if.rdy), 32'd1);
    q.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 0, 1, 8'h99, 0);
    step(1, 0, 1, 8'h9A, 1);
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

endmodule
